// File: rtl/enc_pipe_encoder.sv
// Two-stage SEC-DED (extended Hamming) encoder with valid/ready handshakes on both sides.
// Optional error-injection port and XOR stage enabled by defining ENC_ERR_INJECT_EN.
module enc_pipe_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      data_in,
  input  logic [1:0]       codeword_width,
`ifdef ENC_ERR_INJECT_EN
  input  logic [31:0]      err_inj_mask,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      codeword,
  output logic [1:0]       out_width,
  output logic [CNT_W-1:0] enc_count
);

  function automatic logic [2:0] popcnt5(input logic [4:0] v);
    return {2'd0, v[0]} + {2'd0, v[1]} + {2'd0, v[2]} + {2'd0, v[3]} + {2'd0, v[4]};
  endfunction

  // Data bit j takes the j-th (pm1)-bit column with >= 2 ones; the top check bit is overall parity.
  function automatic logic [5:0] check_bits(input logic [25:0] data, input int pm1);
    logic [4:0] syn;
    logic [4:0] idx;
    logic [4:0] vv;
    logic       ovr;
    syn = 5'd0;
    idx = 5'd0;
    for (int v = 3; v < 32; v++) begin
      vv = v[4:0];
      if ((v < (32'sd1 << pm1)) && (popcnt5(vv) >= 3'd2)) begin
        if (data[idx]) begin
          syn = syn ^ vv;
        end else begin
          syn = syn;
        end
        idx = idx + 5'd1;
      end
    end
    ovr = (^data) ^ (^syn);
    return {1'b0, syn} | ({5'd0, ovr} << pm1);
  endfunction

  function automatic logic [31:0] width_mask(input logic [1:0] w);
    logic [31:0] m;
    case (w)
      2'd0:    m = 32'h0000_00FF;
      2'd1:    m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  logic             r_v1;
  logic [25:0]      r_d1;
  logic [1:0]       r_w1;
  logic             r_v2;
  logic [31:0]      r_cw;
  logic [1:0]       r_ow;
  logic [CNT_W-1:0] r_cnt;
`ifdef ENC_ERR_INJECT_EN
  logic [31:0]      r_m1;
`endif

  logic        w_in_ready;
  logic        w_in_xfer;
  logic        w_out_xfer;
  logic        w_s2_load;
  logic [25:0] w_din_m;
  logic [1:0]  w_w_norm;
  logic [5:0]  w_chk;
  logic [31:0] w_cw;
  logic        w_unused;

  assign w_unused   = ^data_in[31:26];
  assign w_in_ready = ~r_v1 | ~r_v2 | out_ready;
  assign w_in_xfer  = in_valid & w_in_ready;
  assign w_out_xfer = r_v2 & out_ready;
  assign w_s2_load  = r_v1 & (~r_v2 | out_ready);
  assign w_w_norm   = (codeword_width == 2'd3) ? 2'd2 : codeword_width;

  // Drop data bits at and above D so they can never reach the codeword.
  always_comb begin
    w_din_m = 26'd0;
    case (codeword_width)
      2'd0:    w_din_m = {22'd0, data_in[3:0]};
      2'd1:    w_din_m = {15'd0, data_in[10:0]};
      default: w_din_m = data_in[25:0];
    endcase
  end

  // Assemble {data, check bits} for the width carried in stage 1.
  always_comb begin
    w_chk = 6'd0;
    w_cw  = 32'd0;
    case (r_w1)
      2'd0: begin
        w_chk = check_bits(r_d1, 3);
        w_cw  = {24'd0, r_d1[3:0], w_chk[3:0]};
      end
      2'd1: begin
        w_chk = check_bits(r_d1, 4);
        w_cw  = {16'd0, r_d1[10:0], w_chk[4:0]};
      end
      default: begin
        w_chk = check_bits(r_d1, 5);
        w_cw  = {r_d1, w_chk};
      end
    endcase
  end

  // Stage 1: capture masked data and normalised width.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_d1 <= 26'd0;
      r_w1 <= 2'd0;
`ifdef ENC_ERR_INJECT_EN
      r_m1 <= 32'd0;
`endif
    end else if (w_in_xfer) begin
      r_v1 <= 1'b1;
      r_d1 <= w_din_m;
      r_w1 <= w_w_norm;
`ifdef ENC_ERR_INJECT_EN
      r_m1 <= err_inj_mask & width_mask(w_w_norm);
`endif
    end else if (w_s2_load) begin
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= r_v1;
    end
  end

  // Stage 2: register the codeword; held while the downstream side stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2 <= 1'b0;
      r_cw <= 32'd0;
      r_ow <= 2'd0;
    end else if (w_s2_load) begin
      r_v2 <= 1'b1;
`ifdef ENC_ERR_INJECT_EN
      r_cw <= w_cw ^ r_m1;
`else
      r_cw <= w_cw;
`endif
      r_ow <= r_w1;
    end else if (w_out_xfer) begin
      r_v2 <= 1'b0;
    end else begin
      r_v2 <= r_v2;
    end
  end

  // Count codewords accepted downstream; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_out_xfer) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_v2;
  assign codeword  = r_cw;
  assign out_width = r_ow;
  assign enc_count = r_cnt;

endmodule

// File: tb/tb_enc_pipe_encoder.sv
// Self-checking bench for enc_pipe_encoder: directed cases plus randomized traffic against a
// queue-based reference model. Exercises injection when ENC_ERR_INJECT_EN is defined.
module tb_enc_pipe_encoder;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      data_in = 32'd0;
  logic [1:0]       codeword_width = 2'd0;
  logic [31:0]      err_inj_mask = 32'd0;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      codeword;
  logic [1:0]       out_width;
  logic [CNT_W-1:0] enc_count;

  int n_cmp = 0;
  int n_bad = 0;

  enc_pipe_encoder #(.CNT_W(CNT_W)) dut (
`ifdef ENC_ERR_INJECT_EN
    .err_inj_mask   (err_inj_mask),
`endif
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .data_in        (data_in),
    .codeword_width (codeword_width),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .codeword       (codeword),
    .out_width      (out_width),
    .enc_count      (enc_count)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int col_of(input int j);
    int n = 0;
    for (int v = 3; v < 64; v++) begin
      if ($countones(v) >= 2) begin
        if (n == j) return v;
        n++;
      end
    end
    return 0;
  endfunction

  function automatic int dbits(input logic [1:0] w);
    return (w == 2'd0) ? 4 : (w == 2'd1) ? 11 : 26;
  endfunction

  function automatic int pbits(input logic [1:0] w);
    return (w == 2'd0) ? 4 : (w == 2'd1) ? 5 : 6;
  endfunction

  function automatic logic [31:0] cw_mask(input logic [1:0] w);
    logic [63:0] m;
    m = (64'd1 << (dbits(w) + pbits(w))) - 64'd1;
    return m[31:0];
  endfunction

  function automatic logic [31:0] ref_encode(input logic [31:0] din, input logic [1:0] w);
    int d = dbits(w);
    int p = pbits(w);
    int syn = 0;
    int ones = 0;
    for (int j = 0; j < d; j++) begin
      if (din[j]) begin
        syn ^= col_of(j);
        ones++;
      end
    end
    ones += $countones(syn);
    return ((din & ((32'd1 << d) - 32'd1)) << p) | 32'(syn) | (32'(ones % 2) << (p - 1));
  endfunction

  // Scoreboard: expected {width, codeword} per accepted input beat
  logic [33:0] exp_q[$];
  logic [33:0] e_ent;
  logic [31:0] e_cw;
  logic [1:0]  e_w;
  int          exp_cnt = 0;
  logic        held_pend = 1'b0;
  logic [31:0] held_cw = 32'd0;
  logic [1:0]  held_ow = 2'd0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_cnt   = 0;
      held_pend = 1'b0;
    end else begin
      chk_val("enc_count", 32'(enc_count), 32'(exp_cnt));
      if (held_pend) begin
        chk_val("hold_valid", 32'(out_valid), 32'd1);
        chk_val("hold_codeword", codeword, held_cw);
        chk_val("hold_width", 32'(out_width), 32'(held_ow));
      end
      held_pend = out_valid && !out_ready;
      held_cw   = codeword;
      held_ow   = out_width;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk_val("spurious_beat", 32'(out_valid), 32'd0);
        end else begin
          e_ent = exp_q.pop_front();
          chk_val("codeword", codeword, e_ent[31:0]);
          chk_val("out_width", 32'(out_width), 32'(e_ent[33:32]));
        end
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      end
      if (in_valid && in_ready) begin
        e_w  = (codeword_width == 2'd3) ? 2'd2 : codeword_width;
        e_cw = ref_encode(data_in, e_w);
`ifdef ENC_ERR_INJECT_EN
        e_cw = e_cw ^ (err_inj_mask & cw_mask(e_w));
`endif
        exp_q.push_back({e_w, e_cw});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input logic [31:0] d, input logic [1:0] w,
                          input logic [31:0] ecw, input logic [1:0] eow);
    in_valid = 1'b1;
    data_in = d;
    codeword_width = w;
    cyc();
    in_valid = 1'b0;
    data_in = $urandom();
    @(negedge clk);
    chk_val("lat_early", 32'(out_valid), 32'd0);
    cyc();
    @(negedge clk);
    chk_val("lat_valid", 32'(out_valid), 32'd1);
    chk_val("dir_codeword", codeword, ecw);
    chk_val("dir_width", 32'(out_width), 32'(eow));
    cyc();
  endtask

`ifdef ENC_ERR_INJECT_EN
  task automatic decode(input logic [31:0] cw, input logic [1:0] w,
                        output int errs, output logic [31:0] data);
    int d = dbits(w);
    int p = pbits(w);
    int syn = 0;
    int par = 0;
    for (int i = 0; i < p; i++) begin
      if (cw[i]) begin
        par ^= 1;
        if (i < p - 1) syn ^= (1 << i);
      end
    end
    for (int j = 0; j < d; j++) begin
      if (cw[p + j]) begin
        par ^= 1;
        syn ^= col_of(j);
      end
    end
    data = (cw >> p) & ((32'd1 << d) - 32'd1);
    if (syn == 0 && par == 0) begin
      errs = 0;
    end else if (par == 1) begin
      errs = 1;
      for (int j = 0; j < d; j++) if (col_of(j) == syn) data[j] = ~data[j];
    end else begin
      errs = 2;
    end
  endtask
`endif

  logic [31:0] bd[10];
  logic [1:0]  bw[10];
  int          sent;
  int          k;
  logic        acc;

  initial begin
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk_val("rst_out_valid", 32'(out_valid), 32'd0);
    chk_val("rst_codeword", codeword, 32'd0);
    chk_val("rst_out_width", 32'(out_width), 32'd0);
    chk_val("rst_enc_count", 32'(enc_count), 32'd0);
    chk_val("rst_in_ready", 32'(in_ready), 32'd1);
    cyc();

    out_ready = 1'b1;
    directed(32'h0000_0001, 2'd0, 32'h0000_001B, 2'd0);
    directed(32'h0000_0001, 2'd2, 32'h0000_0063, 2'd2);
    directed(32'h0000_0001, 2'd3, 32'h0000_0063, 2'd2);
    directed(32'hFFFF_FFF0, 2'd0, 32'h0000_0000, 2'd0);
    directed(32'h0000_05A5, 2'd1, ref_encode(32'h0000_05A5, 2'd1), 2'd1);

    // Reset with two beats in flight
    out_ready = 1'b0;
    in_valid = 1'b1;
    data_in = $urandom();
    codeword_width = 2'd1;
    cyc();
    data_in = $urandom();
    cyc();
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk_val("flush_out_valid", 32'(out_valid), 32'd0);
    chk_val("flush_enc_count", 32'(enc_count), 32'd0);
    chk_val("flush_in_ready", 32'(in_ready), 32'd1);
    cyc();
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk_val("flush_no_stale", 32'(out_valid), 32'd0);
      cyc();
    end

    // Ten back-to-back beats with a three-cycle downstream stall
    for (int i = 0; i < 10; i++) begin
      bd[i] = $urandom();
      bw[i] = 2'($urandom_range(0, 3));
    end
    sent = 0;
    k = 0;
    while ((sent < 10 || enc_count != 16'd10) && k < 60) begin
      in_valid = (sent < 10);
      if (sent < 10) begin
        data_in = bd[sent];
        codeword_width = bw[sent];
      end
      out_ready = !(k >= 4 && k < 7);
      @(negedge clk);
      if (k == 2) chk_val("burst_full_rate", 32'(in_ready), 32'd1);
      if (k == 5) chk_val("burst_stall_ready", 32'(in_ready), 32'd0);
      acc = in_valid && in_ready;
      cyc();
      if (acc) sent++;
      k++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk_val("burst_count", 32'(enc_count), 32'd10);
    chk_val("burst_drained", 32'(exp_q.size()), 32'd0);
    cyc();

    // Randomized traffic
    repeat (400) begin
      in_valid = 1'($urandom_range(0, 1));
      data_in = $urandom();
      codeword_width = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    chk_val("rand_drained", 32'(exp_q.size()), 32'd0);
    cyc();

`ifdef ENC_ERR_INJECT_EN
    begin
      logic [31:0] idata;
      logic [31:0] ddata;
      int          derrs;
      idata = $urandom();
      for (int t = 0; t < 2; t++) begin
        in_valid = 1'b1;
        data_in = idata;
        codeword_width = 2'd1;
        err_inj_mask = (t == 0) ? 32'h4 : 32'h6;
        cyc();
        in_valid = 1'b0;
        err_inj_mask = 32'd0;
        cyc();
        @(negedge clk);
        chk_val("inj_valid", 32'(out_valid), 32'd1);
        decode(codeword, 2'd1, derrs, ddata);
        chk_val("inj_errs", 32'(derrs), (t == 0) ? 32'd1 : 32'd2);
        if (t == 0) chk_val("inj_data", ddata, idata & 32'h0000_07FF);
        cyc();
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
